// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider: restoring mantissa division, one quotient bit per clock.
// Define FP_DIV_SPECIAL_EN to decode Inf/NaN operands; otherwise exponent 8'hFF is an ordinary value.
module fp_div_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int BIAS       = 127
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_start,
  input  logic [DATA_WIDTH-1:0] in_numA,
  input  logic [DATA_WIDTH-1:0] in_numB,
  output logic                  out_busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_div_by_zero
);
  localparam int MW  = MANT_WIDTH + 1;
  localparam int QW  = MANT_WIDTH + 2;
  localparam int RW  = MANT_WIDTH + 3;
  localparam int EW2 = EXP_WIDTH + 2;
  localparam int CW  = $clog2(MANT_WIDTH + 2);
  localparam logic signed [EW2-1:0] EXP_MAX  = {2'b00, {EXP_WIDTH{1'b1}}};
  localparam logic signed [EW2-1:0] EXP_ZERO = {EW2{1'b0}};

  typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, NORM = 2'd2} state_t;

  state_t                  state_r, state_next_s;
  logic                    sign_r, bypass_r, dbz_r, busy_s;
  logic [EXP_WIDTH-1:0]    exp_a_r, exp_b_r;
  logic [MW-1:0]           mant_b_r;
  logic [RW-1:0]           rem_r, trial_s;
  logic [QW-1:0]           quo_r;
  logic [CW-1:0]           cnt_r;
  logic [DATA_WIDTH-1:0]   special_r, special_s, norm_res_s, out_result_r;
  logic                    out_valid_r, out_dbz_r;
  logic                    sign_s, zero_a_s, zero_b_s, bypass_s, dbz_s, ge_s;
  logic signed [EW2-1:0]   e_s, exp_n_s;
  logic [MANT_WIDTH-1:0]   frac_n_s;

  assign sign_s   = in_numA[DATA_WIDTH-1] ^ in_numB[DATA_WIDTH-1];
  assign zero_a_s = (in_numA[DATA_WIDTH-2 -: EXP_WIDTH] == {EXP_WIDTH{1'b0}});
  assign zero_b_s = (in_numB[DATA_WIDTH-2 -: EXP_WIDTH] == {EXP_WIDTH{1'b0}});

`ifdef FP_DIV_SPECIAL_EN
  logic inf_a_s, inf_b_s, nan_a_s, nan_b_s;
  assign inf_a_s = (in_numA[DATA_WIDTH-2 -: EXP_WIDTH] == {EXP_WIDTH{1'b1}}) &&
                   (in_numA[MANT_WIDTH-1:0] == {MANT_WIDTH{1'b0}});
  assign inf_b_s = (in_numB[DATA_WIDTH-2 -: EXP_WIDTH] == {EXP_WIDTH{1'b1}}) &&
                   (in_numB[MANT_WIDTH-1:0] == {MANT_WIDTH{1'b0}});
  assign nan_a_s = (in_numA[DATA_WIDTH-2 -: EXP_WIDTH] == {EXP_WIDTH{1'b1}}) && !inf_a_s;
  assign nan_b_s = (in_numB[DATA_WIDTH-2 -: EXP_WIDTH] == {EXP_WIDTH{1'b1}}) && !inf_b_s;
`endif

  // Operand classification: decides whether the divide loop is skipped and what the special result is.
  always_comb begin
    bypass_s  = 1'b1;
    dbz_s     = 1'b0;
    special_s = {sign_s, {(DATA_WIDTH-1){1'b0}}};
`ifdef FP_DIV_SPECIAL_EN
    if (nan_a_s || nan_b_s || (zero_a_s && zero_b_s) || (inf_a_s && inf_b_s)) begin
      special_s = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    end else if (inf_a_s) begin
      special_s = {sign_s, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end else if (inf_b_s) begin
      special_s = {sign_s, {(DATA_WIDTH-1){1'b0}}};
    end else if (zero_b_s) begin
      special_s = {sign_s, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      dbz_s     = 1'b1;
    end else if (zero_a_s) begin
      special_s = {sign_s, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      bypass_s  = 1'b0;
    end
`else
    if (zero_a_s) begin
      special_s = {sign_s, {(DATA_WIDTH-1){1'b0}}};
    end else if (zero_b_s) begin
      special_s = {sign_s, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      dbz_s     = 1'b1;
    end else begin
      bypass_s  = 1'b0;
    end
`endif
  end

  assign trial_s = rem_r - {2'b00, mant_b_r};
  assign ge_s    = (rem_r >= {2'b00, mant_b_r});

  // Normalisation: Q lies in [2^23, 2^25), so at most one position of adjustment.
  always_comb begin
    e_s = {2'b00, exp_a_r} - {2'b00, exp_b_r} + EW2'(BIAS);
    if (quo_r[QW-1]) begin
      exp_n_s  = e_s;
      frac_n_s = quo_r[MANT_WIDTH:1];
    end else begin
      exp_n_s  = e_s - {{(EW2-1){1'b0}}, 1'b1};
      frac_n_s = quo_r[MANT_WIDTH-1:0];
    end
    if (exp_n_s >= EXP_MAX) begin
      norm_res_s = {sign_r, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end else if (exp_n_s <= EXP_ZERO) begin
      norm_res_s = {sign_r, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      norm_res_s = {sign_r, exp_n_s[EXP_WIDTH-1:0], frac_n_s};
    end
  end

  // State register.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state_r <= IDLE;
    else           state_r <= state_next_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (in_start) state_next_s = bypass_s ? NORM : DIVIDE;
               else          state_next_s = IDLE;
      DIVIDE:  if (cnt_r == {CW{1'b0}}) state_next_s = NORM;
               else                     state_next_s = DIVIDE;
      NORM:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      DIVIDE, NORM: busy_s = 1'b1;
      default:      busy_s = 1'b0;
    endcase
  end

  // Datapath: operand capture, one restoring step per DIVIDE cycle, result registration in NORM.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sign_r       <= 1'b0;
      bypass_r     <= 1'b0;
      dbz_r        <= 1'b0;
      exp_a_r      <= {EXP_WIDTH{1'b0}};
      exp_b_r      <= {EXP_WIDTH{1'b0}};
      mant_b_r     <= {MW{1'b0}};
      rem_r        <= {RW{1'b0}};
      quo_r        <= {QW{1'b0}};
      cnt_r        <= {CW{1'b0}};
      special_r    <= {DATA_WIDTH{1'b0}};
      out_result_r <= {DATA_WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      out_dbz_r    <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_start) begin
            sign_r    <= sign_s;
            bypass_r  <= bypass_s;
            dbz_r     <= dbz_s;
            special_r <= special_s;
            exp_a_r   <= in_numA[DATA_WIDTH-2 -: EXP_WIDTH];
            exp_b_r   <= in_numB[DATA_WIDTH-2 -: EXP_WIDTH];
            mant_b_r  <= {1'b1, in_numB[MANT_WIDTH-1:0]};
            rem_r     <= {2'b01, in_numA[MANT_WIDTH-1:0]};
            quo_r     <= {QW{1'b0}};
            cnt_r     <= CW'(MANT_WIDTH + 1);
            out_dbz_r <= 1'b0;
          end
        end
        DIVIDE: begin
          rem_r <= ge_s ? (trial_s << 1) : (rem_r << 1);
          quo_r <= {quo_r[QW-2:0], ge_s};
          cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
        NORM: begin
          out_result_r <= bypass_r ? special_r : norm_res_s;
          out_dbz_r    <= dbz_r;
          out_valid_r  <= 1'b1;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign out_busy        = busy_s;
  assign out_valid       = out_valid_r;
  assign out_result      = out_result_r;
  assign out_div_by_zero = out_dbz_r;
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq: hand-computed quotients, latency, handshake and reset.
module tb_fp_div_seq;
  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic [31:0] in_numA = 32'h0;
  logic [31:0] in_numB = 32'h0;
  logic        out_busy, out_valid, out_div_by_zero;
  logic [31:0] out_result;

  int tests_run = 0;
  int tests_failed = 0;

  fp_div_seq dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_start(in_start),
    .in_numA(in_numA), .in_numB(in_numB),
    .out_busy(out_busy), .out_valid(out_valid),
    .out_result(out_result), .out_div_by_zero(out_div_by_zero)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for out_valid; lat counts edges after the start edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic dbz,
                       output int lat, output int busy_cnt);
    @(negedge in_clk);
    in_numA = a; in_numB = b; in_start = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    lat = 0;
    busy_cnt = out_busy ? 1 : 0;
    while (!out_valid && lat < 100) begin
      @(posedge in_clk); #1;
      lat++;
      if (out_busy) busy_cnt++;
    end
    res = out_result;
    dbz = out_div_by_zero;
  endtask

  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_dbz, input int exp_lat);
    logic [31:0] res;
    logic        dbz;
    int          lat, bc;
    do_op(a, b, res, dbz, lat, bc);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_dbz"}, {31'b0, dbz}, {31'b0, exp_dbz});
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge in_clk); #1;
    check({tag, "_1shot"}, {31'b0, out_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] res;
    logic        dbz;
    int          lat, bc, seen;

    #23;
    check("rst_busy", {31'b0, out_busy}, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_result", out_result, 32'h0);
    check("rst_dbz", {31'b0, out_div_by_zero}, 32'h0);
    @(negedge in_clk); in_rst_n = 1'b1;

    do_op(32'h40C00000, 32'h40000000, res, dbz, lat, bc);
    check("six_two_res", res, 32'h40400000);
    check("six_two_dbz", {31'b0, dbz}, 32'h0);
    check("six_two_lat", 32'(lat), 32'd26);
    check("six_two_busy", 32'(bc), 32'd26);

    op_check("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26);
    op_check("neg_six_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 26);
    op_check("div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1);
    op_check("two_one", 32'h40000000, 32'h3F800000, 32'h40000000, 1'b0, 26);
    op_check("zero_num", 32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1);
    op_check("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 26);
    op_check("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 26);

`ifdef FP_DIV_SPECIAL_EN
    op_check("inf_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1);
    op_check("two_inf", 32'h40000000, 32'h7F800000, 32'h00000000, 1'b0, 1);
    op_check("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1);
    op_check("neg_inf_two", 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1);
`else
    op_check("inf_inf", 32'h7F800000, 32'h7F800000, 32'h3F800000, 1'b0, 26);
    op_check("two_inf", 32'h40000000, 32'h7F800000, 32'h00000000, 1'b0, 26);
    op_check("zero_zero", 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1);
`endif

    // A start pulse mid-division must not disturb the running operation.
    @(negedge in_clk);
    in_numA = 32'h40C00000; in_numB = 32'h40000000; in_start = 1'b1;
    @(posedge in_clk); #1; in_start = 1'b0;
    repeat (4) @(posedge in_clk);
    @(negedge in_clk);
    in_numA = 32'h3F800000; in_numB = 32'h40400000; in_start = 1'b1;
    @(negedge in_clk); in_start = 1'b0;
    lat = 5;
    while (!out_valid && lat < 100) begin @(posedge in_clk); #1; lat++; end
    check("ignored_res", out_result, 32'h40400000);
    check("ignored_lat", 32'(lat), 32'd26);
    @(posedge in_clk); #1;
    check("ignored_no_restart", {31'b0, out_busy}, 32'h0);

    // Reset mid-operation: outputs clear at once and the aborted op never completes.
    @(negedge in_clk);
    in_numA = 32'h3F800000; in_numB = 32'h40400000; in_start = 1'b1;
    @(posedge in_clk); #1; in_start = 1'b0;
    repeat (10) @(posedge in_clk);
    #1; in_rst_n = 1'b0; #1;
    check("midrst_busy", {31'b0, out_busy}, 32'h0);
    check("midrst_result", out_result, 32'h0);
    check("midrst_valid", {31'b0, out_valid}, 32'h0);
    repeat (2) @(posedge in_clk);
    @(negedge in_clk); in_rst_n = 1'b1;
    seen = 0;
    repeat (30) begin @(posedge in_clk); #1; if (out_valid || out_busy) seen++; end
    check("midrst_no_valid", 32'(seen), 32'h0);
    op_check("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
